instruction_fetch: RTL and testbench
====================================

// Module: instruction_fetch
// PURPOSE
//  Fetch stage that feeds instruction_decode. Holds the PC and drives a synchronous
//  instruction memory (1-cycle read latency). Registers the fetched word and its PC
//  into the IF/ID pipeline register. Handles stall and branch/jump redirect.
//  Inserts NOP bubbles (32'd0, which decode treats as NOP) while the pipeline refills.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC of the first instruction fetched after reset
//  ADDR_W    8              imem word-address width; imem depth is 2**ADDR_W words
// PORTS
//  clock         in   1       single clock; all state updates on posedge
//  reset_n       in   1       asynchronous reset, active low
//  stall         in   1       hold the IF/ID register and PC (decode/execute busy)
//  redirect      in   1       taken branch/jump; restart fetch at redirect_pc
//  redirect_pc   in   32      target PC; bits [1:0] are ignored and forced to 0
//  imem_addr     out  ADDR_W  word address to the instruction memory
//  imem_rdata    in   32      instruction word for the address presented last cycle
//  instr_out     out  32      IF/ID instruction; connects to decode data_in
//  pc_out        out  32      PC of instr_out
//  instr_valid   out  1       instr_out is a real fetched instruction, not a bubble
//  fetch_count   out  32      number of valid instructions issued since reset
// BEHAVIOUR
//  Registers: fetch_pc (address presented now) and inflight_pc (address presented
//  last cycle, whose data is on imem_rdata now). State machine: FILL, RUN.
//  Reset (async, reset_n=0):
//    state=FILL, fetch_pc=inflight_pc=RESET_PC, instr_out=0, pc_out=RESET_PC,
//    instr_valid=0, fetch_count=0.
//  imem_addr is combinational:
//    (state==RUN && stall && !redirect) ? inflight_pc[ADDR_W+1:2] : fetch_pc[ADDR_W+1:2].
//  Priority is redirect > stall > normal, in both states.
//  FILL (no valid data yet on imem_rdata):
//    redirect: fetch_pc<=redirect_pc&~3; stay FILL.
//    stall: hold all registers; stay FILL.
//    else: inflight_pc<=fetch_pc; fetch_pc<=fetch_pc+4; instr_out<=0; instr_valid<=0;
//      go to RUN.
//  RUN:
//    redirect: fetch_pc<=redirect_pc&~3; instr_out<=0; instr_valid<=0; go to FILL.
//      This squashes the in-flight word (one bubble, then one more from FILL:
//      2-cycle taken-branch penalty).
//    stall: instr_out, pc_out, instr_valid, fetch_pc, inflight_pc and fetch_count
//      all hold. imem re-reads inflight_pc, so imem_rdata is still correct when the
//      stall drops.
//    else: instr_out<=imem_rdata; pc_out<=inflight_pc; instr_valid<=1;
//      inflight_pc<=fetch_pc; fetch_pc<=fetch_pc+4; fetch_count<=fetch_count+1.
//  Latency: first valid instruction (PC=RESET_PC) appears on instr_out 2 cycles after
//    reset release, with no stall.
//  Wrap-around: fetch_pc is 32-bit modulo 2**32. imem_addr wraps modulo 2**ADDR_W.
//    fetch_count wraps at 2**32.
//  A fetched word of 32'd0 is passed through with instr_valid=1. Bubbles are
//    identified only by instr_valid=0.
//  Reset asserted mid-operation immediately returns all outputs to reset values;
//    the pending fetch is lost.
// TESTING
//  1 Reset release, imem[i]=32'h00100093+i, no stall -> cycles 1,2,3 after release:
//    instr_out=0/v0, imem[0]/pc 0/v1, imem[1]/pc 4/v1; fetch_count=2 after cycle 3.
//  2 stall=1 for 3 cycles while instr_out=imem[4] (pc 0x10) -> outputs/count frozen;
//    after release the next word is imem[5] pc 0x14, with no skip or duplicate.
//  3 redirect=1, redirect_pc=0x40 in RUN -> two cycles of instr_out=0/v0, then
//    imem[16] pc 0x40, then imem[17] pc 0x44.
//  4 redirect and stall in the same cycle -> redirect wins. redirect_pc=0x43 fetches
//    pc 0x40 (low bits cleared).
//  5 RESET_PC=0x3FC, ADDR_W=8 -> pc 0x3FC reads imem[255]; next pc 0x400 reads imem[0].
//  6 reset_n pulsed low mid-stream for half a cycle -> outputs 0/RESET_PC/v0/count 0
//    immediately; the sequence from test 1 then restarts.

Source files
------------

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - Fetch stage: PC, synchronous imem addressing, IF/ID register, stall and redirect
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 8
) (
    input  logic              i_clock,
    input  logic              i_reset_n,
    input  logic              i_stall,
    input  logic              i_redirect,
    input  logic [31:0]       i_redirect_pc,
    output logic [ADDR_W-1:0] o_imem_addr,
    input  logic [31:0]       i_imem_rdata,
    output logic [31:0]       o_instr_out,
    output logic [31:0]       o_pc_out,
    output logic              o_instr_valid,
    output logic [31:0]       o_fetch_count
);

    typedef enum logic {S_FILL, S_RUN} state_t;

    state_t      r_state;
    logic [31:0] r_fetch_pc;
    logic [31:0] r_inflight_pc;
    logic [31:0] r_instr;
    logic [31:0] r_pc;
    logic        r_valid;
    logic [31:0] r_count;

    state_t      w_state_nxt;
    logic [31:0] w_fetch_pc_nxt;
    logic [31:0] w_inflight_pc_nxt;
    logic [31:0] w_instr_nxt;
    logic [31:0] w_pc_nxt;
    logic        w_valid_nxt;
    logic [31:0] w_count_nxt;
    logic [31:0] w_target;
    logic [31:0] w_addr_pc;
    logic        w_unused;

    assign w_target = {i_redirect_pc[31:2], 2'b00};

    // While stalled in RUN the memory re-reads the in-flight word so its data is still on rdata at release.
    assign w_addr_pc   = (r_state == S_RUN && i_stall && !i_redirect) ? r_inflight_pc : r_fetch_pc;
    assign o_imem_addr = w_addr_pc[ADDR_W+1:2];
    assign w_unused    = &{1'b0, w_addr_pc[31:ADDR_W+2], w_addr_pc[1:0], i_redirect_pc[1:0]};

    always_comb begin
        w_state_nxt       = r_state;
        w_fetch_pc_nxt    = r_fetch_pc;
        w_inflight_pc_nxt = r_inflight_pc;
        w_instr_nxt       = r_instr;
        w_pc_nxt          = r_pc;
        w_valid_nxt       = r_valid;
        w_count_nxt       = r_count;
        case (r_state)
            S_FILL: begin
                if (i_redirect) begin
                    w_fetch_pc_nxt = w_target;
                end else if (!i_stall) begin
                    w_inflight_pc_nxt = r_fetch_pc;
                    w_fetch_pc_nxt    = r_fetch_pc + 32'd4;
                    w_instr_nxt       = 32'd0;
                    w_valid_nxt       = 1'b0;
                    w_state_nxt       = S_RUN;
                end
            end
            S_RUN: begin
                if (i_redirect) begin
                    w_fetch_pc_nxt = w_target;
                    w_instr_nxt    = 32'd0;
                    w_valid_nxt    = 1'b0;
                    w_state_nxt    = S_FILL;
                end else if (!i_stall) begin
                    w_instr_nxt       = i_imem_rdata;
                    w_pc_nxt          = r_inflight_pc;
                    w_valid_nxt       = 1'b1;
                    w_inflight_pc_nxt = r_fetch_pc;
                    w_fetch_pc_nxt    = r_fetch_pc + 32'd4;
                    w_count_nxt       = r_count + 32'd1;
                end
            end
            default: w_state_nxt = S_FILL;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_fetch_pc    <= RESET_PC;
            r_inflight_pc <= RESET_PC;
            r_instr       <= 32'd0;
            r_pc          <= RESET_PC;
            r_valid       <= 1'b0;
            r_count       <= 32'd0;
        end else begin
            r_fetch_pc    <= w_fetch_pc_nxt;
            r_inflight_pc <= w_inflight_pc_nxt;
            r_instr       <= w_instr_nxt;
            r_pc          <= w_pc_nxt;
            r_valid       <= w_valid_nxt;
            r_count       <= w_count_nxt;
        end
    end

    assign o_instr_out   = r_instr;
    assign o_pc_out      = r_pc;
    assign o_instr_valid = r_valid;
    assign o_fetch_count = r_count;

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - Directed bench for instruction_fetch: fill, stall, redirect, wrap, async reset
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;

    logic [7:0]  addr_a, addr_b;
    logic [31:0] rdata_a, rdata_b;
    logic [31:0] instr_a, pc_a, cnt_a;
    logic [31:0] instr_b, pc_b, cnt_b;
    logic        v_a, v_b;

    logic [31:0] mem [256];

    int errors = 0;
    int checks = 0;

    logic [96:0] got, exp;

    always #5 clk = ~clk;

    // Synchronous instruction memories, one read-cycle latency.
    always @(posedge clk) begin
        rdata_a <= mem[addr_a];
        rdata_b <= mem[addr_b];
    end

    instruction_fetch #(.RESET_PC(32'h0000_0000), .ADDR_W(8)) u_dut (
        .i_clock(clk), .i_reset_n(rst_n), .i_stall(stall), .i_redirect(redirect),
        .i_redirect_pc(redirect_pc), .o_imem_addr(addr_a), .i_imem_rdata(rdata_a),
        .o_instr_out(instr_a), .o_pc_out(pc_a), .o_instr_valid(v_a), .o_fetch_count(cnt_a)
    );

    instruction_fetch #(.RESET_PC(32'h0000_03FC), .ADDR_W(8)) u_dut_hi (
        .i_clock(clk), .i_reset_n(rst_n), .i_stall(stall), .i_redirect(redirect),
        .i_redirect_pc(redirect_pc), .o_imem_addr(addr_b), .i_imem_rdata(rdata_b),
        .o_instr_out(instr_b), .o_pc_out(pc_b), .o_instr_valid(v_b), .o_fetch_count(cnt_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        got = {instr_a, pc_a, v_a, cnt_a}; exp = {32'd0, 32'd0, 1'b0, 32'd0};
        checks++;
        if (got !== exp) begin errors++; $display("FAIL reset_a got=%h exp=%h", got, exp); end
        checks++;
        if (addr_a !== 8'd0) begin errors++; $display("FAIL reset_addr_a got=%h exp=00", addr_a); end
        got = {instr_b, pc_b, v_b, cnt_b}; exp = {32'd0, 32'h3FC, 1'b0, 32'd0};
        checks++;
        if (got !== exp) begin errors++; $display("FAIL reset_b got=%h exp=%h", got, exp); end
    endtask

    task automatic test_fetch();
        rst_n = 1'b1;
        step();
        got = {instr_a, pc_a, v_a, cnt_a}; exp = {32'd0, 32'd0, 1'b0, 32'd0};
        checks++;
        if (got !== exp) begin errors++; $display("FAIL fetch_c1 got=%h exp=%h", got, exp); end
        step();
        exp = {32'h00100093, 32'd0, 1'b1, 32'd1}; got = {instr_a, pc_a, v_a, cnt_a};
        checks++;
        if (got !== exp) begin errors++; $display("FAIL fetch_c2 got=%h exp=%h", got, exp); end
        step();
        exp = {32'h00100094, 32'd4, 1'b1, 32'd2}; got = {instr_a, pc_a, v_a, cnt_a};
        checks++;
        if (got !== exp) begin errors++; $display("FAIL fetch_c3 got=%h exp=%h", got, exp); end
    endtask

    task automatic test_stall();
        repeat (3) step();
        exp = {32'h00100097, 32'h10, 1'b1, 32'd5}; got = {instr_a, pc_a, v_a, cnt_a};
        checks++;
        if (got !== exp) begin errors++; $display("FAIL stall_pre got=%h exp=%h", got, exp); end
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (addr_a !== 8'd5) begin errors++; $display("FAIL stall_addr%0d got=%h exp=05", i, addr_a); end
            step();
            got = {instr_a, pc_a, v_a, cnt_a};
            checks++;
            if (got !== exp) begin errors++; $display("FAIL stall_hold%0d got=%h exp=%h", i, got, exp); end
        end
        stall = 1'b0;
        step();
        exp = {32'h00100098, 32'h14, 1'b1, 32'd6}; got = {instr_a, pc_a, v_a, cnt_a};
        checks++;
        if (got !== exp) begin errors++; $display("FAIL stall_rel1 got=%h exp=%h", got, exp); end
        step();
        exp = {32'h00100099, 32'h18, 1'b1, 32'd7}; got = {instr_a, pc_a, v_a, cnt_a};
        checks++;
        if (got !== exp) begin errors++; $display("FAIL stall_rel2 got=%h exp=%h", got, exp); end
    endtask

    task automatic test_redirect();
        redirect = 1'b1; redirect_pc = 32'h40;
        step();
        redirect = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({instr_a, v_a, cnt_a} !== {32'd0, 1'b0, 32'd7}) begin
                errors++; $display("FAIL redir_bubble%0d got=%h/%b/%0d exp=0/0/7", i, instr_a, v_a, cnt_a);
            end
            step();
        end
        exp = {32'h001000A3, 32'h40, 1'b1, 32'd8}; got = {instr_a, pc_a, v_a, cnt_a};
        checks++;
        if (got !== exp) begin errors++; $display("FAIL redir_t0 got=%h exp=%h", got, exp); end
        step();
        exp = {32'h001000A4, 32'h44, 1'b1, 32'd9}; got = {instr_a, pc_a, v_a, cnt_a};
        checks++;
        if (got !== exp) begin errors++; $display("FAIL redir_t1 got=%h exp=%h", got, exp); end
    endtask

    task automatic test_redirect_stall();
        redirect = 1'b1; stall = 1'b1; redirect_pc = 32'h43;
        #1;
        checks++;
        if (addr_a !== 8'd19) begin errors++; $display("FAIL rs_addr got=%0d exp=19", addr_a); end
        step();
        redirect = 1'b0; stall = 1'b0;
        #1;
        checks++;
        if ({instr_a, v_a, addr_a} !== {32'd0, 1'b0, 8'd16}) begin
            errors++; $display("FAIL rs_bubble got=%h/%b/%0d exp=0/0/16", instr_a, v_a, addr_a);
        end
        step();
        checks++;
        if ({instr_a, v_a} !== {32'd0, 1'b0}) begin errors++; $display("FAIL rs_bubble2 got=%h/%b exp=0/0", instr_a, v_a); end
        step();
        exp = {32'h001000A3, 32'h40, 1'b1, 32'd10}; got = {instr_a, pc_a, v_a, cnt_a};
        checks++;
        if (got !== exp) begin errors++; $display("FAIL rs_t0 got=%h exp=%h", got, exp); end
        step();
        exp = {32'h001000A4, 32'h44, 1'b1, 32'd11}; got = {instr_a, pc_a, v_a, cnt_a};
        checks++;
        if (got !== exp) begin errors++; $display("FAIL rs_t1 got=%h exp=%h", got, exp); end
    endtask

    task automatic test_mid_reset();
        step();
        rst_n = 1'b0;
        #1;
        got = {instr_a, pc_a, v_a, cnt_a}; exp = {32'd0, 32'd0, 1'b0, 32'd0};
        checks++;
        if (got !== exp) begin errors++; $display("FAIL mrst_out got=%h exp=%h", got, exp); end
        checks++;
        if (addr_a !== 8'd0) begin errors++; $display("FAIL mrst_addr got=%h exp=00", addr_a); end
        #4;
        rst_n = 1'b1;
        step();
        got = {instr_a, pc_a, v_a, cnt_a};
        checks++;
        if (got !== exp) begin errors++; $display("FAIL mrst_c1 got=%h exp=%h", got, exp); end
        step();
        exp = {32'h00100093, 32'd0, 1'b1, 32'd1}; got = {instr_a, pc_a, v_a, cnt_a};
        checks++;
        if (got !== exp) begin errors++; $display("FAIL mrst_c2 got=%h exp=%h", got, exp); end
        step();
        exp = {32'h00100094, 32'd4, 1'b1, 32'd2}; got = {instr_a, pc_a, v_a, cnt_a};
        checks++;
        if (got !== exp) begin errors++; $display("FAIL mrst_c3 got=%h exp=%h", got, exp); end
    endtask

    task automatic test_wrap();
        rst_n = 1'b0;
        step();
        checks++;
        if (addr_b !== 8'hFF) begin errors++; $display("FAIL wrap_addr got=%h exp=ff", addr_b); end
        rst_n = 1'b1;
        step();
        got = {instr_b, pc_b, v_b, cnt_b}; exp = {32'd0, 32'h3FC, 1'b0, 32'd0};
        checks++;
        if (got !== exp) begin errors++; $display("FAIL wrap_c1 got=%h exp=%h", got, exp); end
        checks++;
        if (addr_b !== 8'h00) begin errors++; $display("FAIL wrap_addr2 got=%h exp=00", addr_b); end
        step();
        exp = {32'h00100192, 32'h3FC, 1'b1, 32'd1}; got = {instr_b, pc_b, v_b, cnt_b};
        checks++;
        if (got !== exp) begin errors++; $display("FAIL wrap_c2 got=%h exp=%h", got, exp); end
        step();
        exp = {32'h00100093, 32'h400, 1'b1, 32'd2}; got = {instr_b, pc_b, v_b, cnt_b};
        checks++;
        if (got !== exp) begin errors++; $display("FAIL wrap_c3 got=%h exp=%h", got, exp); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h00100093 + i;
        test_reset();
        test_fetch();
        test_stall();
        test_redirect();
        test_redirect_stall();
        test_mid_reset();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
